// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, reset vector and the fetch queue entry type
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: in-order fetch entry storage with push/pop, flush to empty and head read-out
module fq_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential PC fetch with credit-limited memory requests, in-order
// instruction queue to decode, and redirect flush that drops stale in-flight words
module fetch_queue import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   inst_pc_plus4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] count, outstanding, outstanding_nxt, drop_cnt;
  logic req_fire, push, pop, nonempty;
  fetch_entry_t head, push_entry;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign nonempty = count != '0;
  // buffered words plus words in flight never exceed the queue capacity
  assign imem_req_valid = rst_n && !redirect_valid && ({1'b0, count} + {1'b0, outstanding} < LIMIT);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign push_entry = '{inst: imem_rsp_data, pc: rsp_pc};
  assign inst_valid = nonempty && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst = nonempty ? head.inst : '0;
  assign inst_pc = nonempty ? head.pc : '0;
  assign inst_pc_plus4 = nonempty ? head.pc + 32'd4 : '0;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  always_ff @(posedge clk)
    if (rst_n)
      assert ({1'b0, count} + {1'b0, outstanding} <= LIMIT && drop_cnt <= outstanding &&
              !(imem_rsp_valid && outstanding == '0));
  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(push),
    .push_entry(push_entry),
    .pop(pop),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed stimulus against an epoch-tagged memory/stream model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 1;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst, inst_pc, inst_pc_plus4;
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
  );
  typedef struct {
    logic [31:0] addr;
    int epoch;
    int due;
  } req_t;
  req_t pend[$];
  int total = 0, bad = 0, cyc = 0, epoch = 0, buffered = 0, lat_lo = 1, lat_hi = 1, dut_fires = 0;
  logic [31:0] exp_fetch = 0, exp_pc = 0, last_head_pc = 0, last_head_p4 = 0, last_req_addr = 0, wrap_p4 = 32'h1;
  bit head_seen = 0, wrap_seen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rdy, input bit ird, input bit redir, input logic [31:0] rpc);
    bit exp_rv, exp_iv, rsp, fire;
    @(negedge clk);
    rsp = pend.size() != 0 && pend[0].due <= cyc;
    imem_req_ready = rdy;
    inst_ready = ird;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_rv = !redir && (buffered + pend.size() < DEPTH);
    exp_iv = !redir && buffered != 0;
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, exp_fetch);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, mem_word(exp_pc));
      check("pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
    end
    if (inst_valid && !head_seen) begin
      head_seen = 1;
      last_head_pc = inst_pc;
      last_head_p4 = inst_pc_plus4;
    end
    if (inst_valid && inst_pc == 32'hFFFFFFFC) begin
      wrap_seen = 1;
      wrap_p4 = inst_pc_plus4;
    end
    last_req_addr = imem_req_addr;
    if (imem_req_valid && rdy) dut_fires++;
    fire = exp_rv && rdy;
    if (rsp) begin
      if (pend[0].epoch == epoch && !redir) buffered++;
      void'(pend.pop_front());
    end
    if (exp_iv && ird) begin
      buffered--;
      exp_pc += 32'd4;
    end
    if (fire) begin
      pend.push_back('{addr: exp_fetch, epoch: epoch, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      exp_fetch += 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
      exp_fetch = {rpc[31:2], 2'b00};
      exp_pc = exp_fetch;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    imem_req_ready = 0;
    inst_ready = 0;
    redirect_valid = 0;
    imem_rsp_valid = 0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_pc_plus4", inst_pc_plus4, 32'h0);
    pend.delete();
    buffered = 0;
    exp_fetch = 0;
    exp_pc = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0);
    check("seq_pc_after_20", exp_pc, 32'd4 * 32'd18);
    do_reset();
    dut_fires = 0;
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0);
    check("stall_issued", dut_fires, DEPTH);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0, 0);
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int g = 0; g < 20 && pend.size() != 2; g++) cycle(1, 1, 0, 0);
    check("redir_outstanding", pend.size(), 2);
    head_seen = 0;
    cycle(1, 1, 1, 32'h100);
    for (int g = 0; g < 20 && !head_seen; g++) cycle(1, 1, 0, 0);
    check("redir_head_seen", {31'b0, head_seen}, 32'h1);
    check("redir_head_pc", last_head_pc, 32'h100);
    check("redir_head_p4", last_head_p4, 32'h104);
    lat_lo = 2; lat_hi = 2;
    for (int g = 0; g < 30 && !(pend.size() != 0 && pend[0].due <= cyc && buffered > 0); g++) cycle(1, 1, 0, 0);
    check("coinc_setup", {31'b0, pend.size() != 0 && buffered > 0}, 32'h1);
    cycle(1, 1, 1, 32'h203);
    cycle(1, 1, 0, 0);
    check("coinc_fetch_addr", last_req_addr, 32'h200);
    head_seen = 0;
    for (int g = 0; g < 20 && !head_seen; g++) cycle(1, 1, 0, 0);
    check("coinc_head_pc", last_head_pc, 32'h200);
    lat_lo = 1; lat_hi = 3;
    cycle(1, 1, 1, 32'hFFFFFFF8);
    for (int g = 0; g < 30 && !wrap_seen; g++) cycle(1, 1, 0, 0);
    check("wrap_seen", {31'b0, wrap_seen}, 32'h1);
    check("wrap_pc_plus4", wrap_p4, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    do_reset();
    head_seen = 0;
    for (int g = 0; g < 20 && !head_seen; g++) cycle(1, 1, 0, 0);
    check("restart_head_pc", last_head_pc, 32'h0);
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
